jk_flip_flop_bank: RTL
======================

Name: jk_flip_flop_bank

Overview:
- Parametrised bank of WIDTH independent JK-style storage bits with a shared clock, enable and mode select.
- Each bit can be treated as a JK, D, T or SR flip-flop.
- Adds change reporting, SR-conflict detection and an optional saturating toggle-event counter.
- Serves as the general-purpose multi-bit state element for control and sequencing logic.

Parameters:
- WIDTH, 8, number of flip-flop bits (>=1)
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset
- CNT_W, 8, width of toggle_count (>=2)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  update strobe; 0 = all bits hold
- mode  input  2  00 JK, 01 D, 10 T, 11 SR (applies to all bits)
- j  input  WIDTH  J / D / T / S input per bit, by mode
- k  input  WIDTH  K / unused / unused / R input per bit, by mode
- q  output  WIDTH  stored state
- q_not  output  WIDTH  always bitwise ~q, registered alongside q
- changed  output  WIDTH  per-bit flag: bit changed value on the last clock edge
- sr_conflict  output  1  1 for one cycle after an SR-mode edge with any bit having S=R=1
- toggle_count  output  CNT_W  saturating count of edges where changed != 0

Behaviour:
- Reset (asynchronous, active-high): q=RESET_VALUE, q_not=~RESET_VALUE, changed=0, sr_conflict=0, toggle_count=0. Reset wins over every other input.
- Deassertion of reset takes effect at the next rising edge; no update occurs on the edge where reset is still high.
- All state updates occur on the rising clock edge. Outputs reflect the new state 1 cycle after the inputs are sampled; no combinational path exists from inputs to outputs.
- enable=0: q and q_not hold, changed=0, sr_conflict=0, toggle_count holds.
- enable=1, per bit i, next q[i] by mode:
  - JK (00): j=0,k=0 hold; j=1,k=0 set; j=0,k=1 clear; j=1,k=1 toggle.
  - D (01): q[i]=j[i]; k ignored.
  - T (10): j[i]=1 toggles, j[i]=0 holds; k ignored.
  - SR (11): S=1,R=0 set; S=0,R=1 clear; S=0,R=0 hold; S=1,R=1 hold (illegal combination).
- q_not is updated in the same edge as q and is never equal to q, including during reset.
- changed[i] = next q[i] XOR current q[i], registered; it is cleared on any edge where enable=0.
- sr_conflict is registered: set on an enabled SR-mode edge where (j & k) != 0, otherwise cleared. It is a single-cycle pulse unless the condition repeats.
- toggle_count increments by 1 on each edge whose computed changed vector is nonzero.
  - It saturates at 2^CNT_W-1; there is no wrap.
  - It is cleared only by reset.
- Changing mode between edges is legal; the mode sampled at the edge applies.
- Mid-operation reset asserted asynchronously immediately forces all reset values, regardless of clock phase.

Optional Feature:
- Macro: JK_BANK_COUNT_EN
- Defined: toggle_count logic is compiled in, as specified above.
- Undefined: the counter register is omitted, toggle_count is tied to 0, and all other behaviour is unchanged.

Test Plan:
- Reset check: WIDTH=8, RESET_VALUE=8'hA5; assert reset mid-cycle -> q=8'hA5, q_not=8'h5A, changed=0 and toggle_count=0 immediately, without waiting for a clock edge.
- JK truth table: from q=8'h00, enable=1, mode=00, j=8'hF0, k=8'h0F -> q=8'hF0, changed=8'hF0. Next edge with j=k=8'hFF -> q=8'h0F, changed=8'hFF.
- D and T modes:
  - mode=01, j=8'h3C, k=8'hFF -> q=8'h3C.
  - Then mode=10, j=8'h01 on 3 edges -> q sequence 3D, 3C, 3D; toggle_count +3.
- SR conflict: q=8'h00, mode=11, j=8'h81, k=8'h01 -> q=8'h80 (bit0 holds), sr_conflict=1 for exactly one cycle. Repeat with k=0 -> sr_conflict=0.
- Enable and hold: enable=0 with mode=00, j=k=8'hFF for 5 edges -> q unchanged, changed=0, toggle_count unchanged.
- Saturation (JK_BANK_COUNT_EN defined, CNT_W=2): 5 consecutive toggling edges in T mode with j=8'h01 -> toggle_count 1,2,3,3,3. With the macro undefined -> toggle_count stays 0.

Source files
------------

// File: rtl/jk_flip_flop_bank.sv
// Bank of WIDTH JK/D/T/SR flip-flops with change flags, SR-conflict pulse and toggle counter.
// One-cycle registered latency, no backpressure; define JK_BANK_COUNT_EN to build the saturating counter.
module jk_flip_flop_bank #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not,
  output logic [WIDTH-1:0] changed,
  output logic             sr_conflict,
  output logic [CNT_W-1:0] toggle_count
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_not_q;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic             sr_conflict_q, sr_conflict_d;

  always_comb begin
    q_d           = q_q;
    changed_d     = '0;
    sr_conflict_d = 1'b0;
    if (enable) begin
      case (mode_e'(mode))
        MODE_JK: q_d = (j & ~q_q) | (~k & q_q);
        MODE_D:  q_d = j;
        MODE_T:  q_d = j ^ q_q;
        // S=R=1 falls into the hold term: only a lone R clears a bit.
        MODE_SR: q_d = (j & ~k) | (q_q & ~(~j & k));
        default: q_d = q_q;
      endcase
      changed_d     = q_d ^ q_q;
      sr_conflict_d = (mode_e'(mode) == MODE_SR) && (|(j & k));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q           <= RESET_VALUE;
      q_not_q       <= ~RESET_VALUE;
      changed_q     <= '0;
      sr_conflict_q <= 1'b0;
    end else begin
      q_q           <= q_d;
      q_not_q       <= ~q_d;
      changed_q     <= changed_d;
      sr_conflict_q <= sr_conflict_d;
    end
  end

`ifdef JK_BANK_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((|changed_d) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign toggle_count = cnt_q;
`else
  assign toggle_count = '0;
`endif

  assign q           = q_q;
  assign q_not       = q_not_q;
  assign changed     = changed_q;
  assign sr_conflict = sr_conflict_q;

endmodule
